// File: rtl/alu_core.sv
// alu_core: registered signed ALU, eight ops, BW+1-bit exact result with {overflow, negative, zero} flags
module alu_core #(
  parameter int BW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [BW-1:0] in_a,
  input  logic signed [BW-1:0] in_b,
  input  logic [2:0]           opcode,
  output logic signed [BW:0]   out,
  output logic [2:0]           flags
);
  logic signed [BW:0] a, b, res;
  logic [BW-1:0] lg;
  assign a = {in_a[BW-1], in_a};
  assign b = {in_b[BW-1], in_b};
  always_comb begin
    lg  = opcode == 3'b010 ? in_a & in_b :
          opcode == 3'b011 ? in_a | in_b :
          opcode == 3'b100 ? in_a ^ in_b :
          opcode == 3'b110 ? in_a : in_b;
    res = opcode == 3'b000 ? a + b :
          opcode == 3'b001 ? a - b :
          opcode == 3'b101 ? a + (BW+1)'(1) : {lg[BW-1], lg};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out   <= '0;
      flags <= 3'b001;
    end else begin
      out   <= res;
      flags <= {res[BW] != res[BW-1], res[BW], res == '0};
    end
  end
endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed vectors plus a randomised run against an integer reference model
module tb_alu_core;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [15:0] in_a = '0, in_b = '0;
  logic [2:0] opcode = '0;
  logic signed [16:0] out;
  logic [2:0] flags;
  int vectors = 0, miscompares = 0;

  alu_core #(.BW(16)) dut (
    .clk(clk), .rst(rst), .in_a(in_a), .in_b(in_b), .opcode(opcode), .out(out), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [16:0] eo, input logic [2:0] ef);
    vectors++;
    assert ({out, flags} === {eo, ef}) else begin
      miscompares++;
      $error("FAIL %s: out=%h flags=%b expected out=%h flags=%b", tag, out, flags, eo, ef);
    end
  endtask

  task automatic run(input string tag, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                     input logic [16:0] eo, input logic [2:0] ef);
    @(negedge clk);
    opcode = op; in_a = a; in_b = b;
    @(posedge clk);
    #1 chk(tag, eo, ef);
  endtask

  // Integer-domain model: exact arithmetic, range test for overflow
  function automatic logic [19:0] model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    int sa, sb, r;
    logic [15:0] l;
    sa = int'($signed(a));
    sb = int'($signed(b));
    l = op == 3'd2 ? (a & b) : op == 3'd3 ? (a | b) : op == 3'd4 ? (a ^ b) : op == 3'd6 ? a : b;
    r = op == 3'd0 ? sa + sb : op == 3'd1 ? sa - sb : op == 3'd5 ? sa + 1 : int'($signed(l));
    model = {r[16:0], (r > 32767 || r < -32768), r < 0, r == 0};
  endfunction

  initial begin
    logic [19:0] m;
    logic [2:0] op;
    logic [15:0] a, b;
    rst = 1'b1;
    in_a = 16'($urandom); in_b = 16'($urandom); opcode = 3'($urandom);
    @(posedge clk);
    @(negedge clk);
    in_a = 16'($urandom); in_b = 16'($urandom); opcode = 3'($urandom);
    @(posedge clk);
    #1 chk("reset", 17'h00000, 3'b001);
    @(negedge clk);
    rst = 1'b0;
    run("add_3_4", 3'd0, 16'd3, 16'd4, 17'h00007, 3'b000);
    run("add_ovf_pos", 3'd0, 16'h7FFF, 16'h0001, 17'h08000, 3'b100);
    run("add_ovf_neg", 3'd0, 16'h8000, 16'h8000, 17'h10000, 3'b110);
    run("sub_ovf", 3'd1, 16'h8000, 16'h0001, 17'h17FFF, 3'b110);
    run("sub_min_min", 3'd1, 16'h8000, 16'h8000, 17'h00000, 3'b001);
    run("sub_zero", 3'd1, 16'd5, 16'd5, 17'h00000, 3'b001);
    run("inc_neg1", 3'd5, 16'hFFFF, 16'h1234, 17'h00000, 3'b001);
    run("inc_max", 3'd5, 16'h7FFF, 16'h0000, 17'h08000, 3'b100);
    run("and", 3'd2, 16'hFF00, 16'h0FF0, 17'h00F00, 3'b000);
    run("and_neg", 3'd2, 16'hFF00, 16'hF0F0, 17'h1F000, 3'b010);
    run("or", 3'd3, 16'h00F0, 16'h000F, 17'h000FF, 3'b000);
    run("xor_self", 3'd4, 16'd1234, 16'd1234, 17'h00000, 3'b001);
    run("mova_neg5", 3'd6, 16'hFFFB, 16'h0007, 17'h1FFFB, 3'b010);
    run("movb_zero", 3'd7, 16'h0055, 16'h0000, 17'h00000, 3'b001);
    // Inputs wiggle between edges; only the last value before the edge counts
    @(negedge clk);
    opcode = 3'd0; in_a = 16'd1; in_b = 16'd1;
    #1 chk("hold1", 17'h00000, 3'b001);
    opcode = 3'd1; in_a = 16'd9; in_b = 16'd2;
    #1 chk("hold2", 17'h00000, 3'b001);
    opcode = 3'd3; in_a = 16'd1; in_b = 16'd2;
    @(posedge clk);
    #1 chk("last_sampled", 17'h00003, 3'b000);
    @(negedge clk);
    opcode = 3'd0; in_a = 16'd3; in_b = 16'd4; rst = 1'b1;
    @(posedge clk);
    #1 chk("reset_midstream", 17'h00000, 3'b001);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      op = 3'($urandom);
      a = i % 7 == 0 ? 16'h8000 : i % 11 == 0 ? 16'h7FFF : 16'($urandom);
      b = i % 5 == 0 ? 16'h8000 : 16'($urandom);
      m = model(op, a, b);
      run("random", op, a, b, m[19:3], m[2:0]);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
